fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the combinational instruction memory: owns the PC, drives the memory address, and captures each returned word.
//  Buffers fetched words in a 2-entry FIFO and hands them to decode over a valid/ready handshake.
//  Handles branch/jump redirects, stalls (decode backpressure), and start/halt control from the testbench or CPU top.
// PARAMETERS
//  RESET_PC   32'h0   PC value loaded on reset
//  ADDR_W     32      PC / memory address width (bits)
//  DATA_W     32      instruction width (bits)
// PORTS
//  Clk              in   1       clock, all state on rising edge
//  Reset            in   1       asynchronous, active-high reset
//  Start            in   1       IDLE/HALTED -> RUN
//  Halt             in   1       RUN -> DRAIN (stop fetching, drain buffer)
//  Redirect_Valid   in   1       load new PC, flush buffer
//  Redirect_Target  in   ADDR_W  new PC byte address
//  IM_Address       out  ADDR_W  address to instruction memory (= PC)
//  IM_Instruction   in   DATA_W  word returned combinationally for IM_Address
//  Out_Valid        out  1       head of buffer valid
//  Out_Ready        in   1       decode accepts head this cycle
//  Out_Instruction  out  DATA_W  head instruction
//  Out_PC           out  ADDR_W  address the head was fetched from
//  Out_PCPlus4      out  ADDR_W  Out_PC + 4, modulo 2^ADDR_W
//  Misaligned       out  1       1-cycle pulse: redirect target had bits[1:0] != 0
//  State            out  2       current FSM state (debug)
//  Fetch_Count      out  32      handshakes completed since reset; wraps at 2^32
// BEHAVIOUR
//  Reset values: PC=RESET_PC, buffer empty, Out_Valid=0, Misaligned=0, State=IDLE, Fetch_Count=0.
//  IM_Address = PC at all times (combinational from PC register).
//  FSM: IDLE -Start-> RUN; RUN -Halt-> DRAIN; DRAIN -(buffer empty)-> HALTED; HALTED -Start-> RUN.
//   Halt has priority over Start when both are asserted.
//  Fetch, in RUN only: push {IM_Instruction, PC} when buffer not full, or when full and popping this cycle; then PC <= PC+4.
//   If no push occurs, PC holds.
//  Pop: Out_Valid & Out_Ready. Out_* always reflect the buffer head; outputs are stable while Out_Valid=1 and Out_Ready=0.
//  Latency: Start sampled at cycle n -> RUN at n+1 -> first word pushed at n+1 -> Out_Valid=1 at n+2.
//  Redirect_Valid has priority over all other events in its cycle:
//   - buffer flushed (including an unaccepted head); no push, no pop counted
//   - PC <= {Redirect_Target[ADDR_W-1:2], 2'b00}
//   - Misaligned=1 next cycle iff Redirect_Target[1:0] != 0
//   - state unchanged, except DRAIN -> HALTED
//  Redirect in IDLE/HALTED loads PC only.
//  Wrap-around: PC 32'hFFFFFFFC + 4 -> 32'h0; Out_PCPlus4 wraps the same way.
//  Buffer: DEPTH 2. Full + push + pop in the same cycle is legal (occupancy unchanged). Empty + pop cannot occur (Out_Valid=0).
//  Halt in the same cycle as a fetch: that fetch still completes; no further pushes.
//  Reset mid-operation: all state returns to reset values immediately (async); buffered words are discarded.
// STRUCTURE
//  Package fetch_pkg: state enum (IDLE=0, RUN=1, DRAIN=2, HALTED=3), PC_INC=4, NOP_INSTR=32'h0.
//  Sub-module fetch_fifo:
//   - 2-entry FIFO, parameterised width (DATA_W + ADDR_W)
//   - ports: push/pop/flush, full/empty, head
//   - same Clk/Reset as parent
//  Top level holds the PC, FSM, redirect logic and Fetch_Count.
// TESTING (IM preloaded: word at address A = A + 32'h1000)
//  1. Reset with Start=0 for 3 cycles -> IM_Address=0, Out_Valid=0, State=0, Fetch_Count=0.
//  2. Start pulse, Out_Ready=1 -> from 2 cycles later, Out_PC=0,4,8,12 on consecutive cycles
//     with Out_Instruction=32'h1000,1004,1008,100C; Fetch_Count increments each cycle.
//  3. Out_Ready=0 for 5 cycles mid-run -> buffer holds 2 words, IM_Address frozen, head stable;
//     on release, sequence continues with no gap or duplicate.
//  4. Redirect_Target=128 while 2 words buffered -> next Out_PC=128, Out_Instruction=32'h1080; no stale word appears.
//     Redirect_Target=32'h1E -> next Out_PC=32'h1C and Misaligned pulses for exactly 1 cycle.
//  5. Halt at PC=16 -> remaining buffered words delivered, State 2 then 3, Out_Valid=0.
//     Start -> fetch resumes at the held PC with no skip.
//  6. Async Reset asserted between clock edges during RUN -> outputs return to reset values before the next edge;
//     after release, Start refetches from 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  // Fetch FSM states; encoding is visible on the State debug port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  // Byte stride between consecutive instruction words.
  localparam logic [31:0] PC_INC = 32'd4;

  // Instruction presented to decode while nothing valid is buffered.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO holding fetched {instruction, pc} pairs for decode.
// Full with simultaneous push and pop keeps occupancy at two; flush empties it.
module fetch_fifo #(
  parameter int WIDTH = 64
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  // Pointer and occupancy tracking; flush discards everything buffered.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; contents are meaningless while count is zero.
  always_ff @(posedge Clk) begin
    if (push && !flush) mem[wr_ptr] <= data;
  end

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, drives the combinational
// instruction memory, buffers fetched words and hands them to decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Halt,
  input  logic              Redirect_Valid,
  input  logic [ADDR_W-1:0] Redirect_Target,
  output logic [ADDR_W-1:0] IM_Address,
  input  logic [DATA_W-1:0] IM_Instruction,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Out_Instruction,
  output logic [ADDR_W-1:0] Out_PC,
  output logic [ADDR_W-1:0] Out_PCPlus4,
  output logic              Misaligned,
  output logic [1:0]        State,
  output logic [31:0]       Fetch_Count
);

  localparam int ENTRY_W = DATA_W + ADDR_W;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   pc_next;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  head;

  fetch_fifo #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (push),
    .pop   (pop),
    .flush (Redirect_Valid),
    .data  ({IM_Instruction, pc}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // Handshake, fetch decision, next PC and next state; a redirect overrides all.
  always_comb begin
    pop        = !fifo_empty && Out_Ready && !Redirect_Valid;
    push       = (state == RUN) && !Redirect_Valid && (!fifo_full || pop);
    state_next = state;
    pc_next    = pc;
    if (Redirect_Valid) begin
      pc_next = {Redirect_Target[ADDR_W-1:2], 2'b00};
      // A flushed buffer is empty, so draining is already complete.
      if (state == DRAIN) state_next = HALTED;
    end else begin
      if (push) pc_next = pc + ADDR_W'(PC_INC);
      case (state)
        IDLE, HALTED: if (Start && !Halt) state_next = RUN;
        RUN:          if (Halt) state_next = DRAIN;
        DRAIN:        if (fifo_empty) state_next = HALTED;
        default:      state_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Program counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) pc <= RESET_PC;
    else       pc <= pc_next;
  end

  // One-cycle flag for a redirect target that was not word aligned.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) Misaligned <= 1'b0;
    else       Misaligned <= Redirect_Valid && (Redirect_Target[1:0] != 2'b00);
  end

  // Count of completed decode handshakes; wraps naturally.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)    Fetch_Count <= 32'd0;
    else if (pop) Fetch_Count <= Fetch_Count + 32'd1;
  end

  assign IM_Address      = pc;
  assign Out_Valid       = !fifo_empty;
  assign Out_PC          = head[ADDR_W-1:0];
  assign Out_Instruction = fifo_empty ? DATA_W'(NOP_INSTR) : head[ENTRY_W-1:ADDR_W];
  assign Out_PCPlus4     = Out_PC + ADDR_W'(PC_INC);
  assign State           = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with hand-derived values,
// then randomized traffic against a queue-based reference model.
module tb_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, Start, Halt, Redirect_Valid, Out_Ready;
  logic [31:0] Redirect_Target, IM_Address, IM_Instruction;
  logic [31:0] Out_Instruction, Out_PC, Out_PCPlus4, Fetch_Count;
  logic        Out_Valid, Misaligned;
  logic [1:0]  State;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t      m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  int          m_state;
  logic        m_mis;

  always #5 Clk = ~Clk;

  // Instruction memory contents: word at address A is A + 0x1000.
  assign IM_Instruction = IM_Address + 32'h1000;

  fetch_sequencer dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .Start           (Start),
    .Halt            (Halt),
    .Redirect_Valid  (Redirect_Valid),
    .Redirect_Target (Redirect_Target),
    .IM_Address      (IM_Address),
    .IM_Instruction  (IM_Instruction),
    .Out_Valid       (Out_Valid),
    .Out_Ready       (Out_Ready),
    .Out_Instruction (Out_Instruction),
    .Out_PC          (Out_PC),
    .Out_PCPlus4     (Out_PCPlus4),
    .Misaligned      (Misaligned),
    .State           (State),
    .Fetch_Count     (Fetch_Count)
  );

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Halt = 1'b0; Redirect_Valid = 1'b0;
    Redirect_Target = 32'h0; Out_Ready = 1'b0;
    repeat (3) tick();
    checks++; if (IM_Address !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want %h", IM_Address, 32'h0); end
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", Out_Valid); end
    checks++; if (State !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", State); end
    checks++; if (Fetch_Count !== 32'h0) begin errors++; $display("FAIL reset_count: got %0d want 0", Fetch_Count); end
    checks++; if (Misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b want 0", Misaligned); end
    Reset = 1'b0;
    tick();
    checks++; if (State !== 2'd0) begin errors++; $display("FAIL idle_hold: got %0d want 0", State); end
  endtask

  task automatic test_stream();
    Start = 1'b1; Out_Ready = 1'b1;
    tick();
    Start = 1'b0;
    checks++; if (State !== 2'd1) begin errors++; $display("FAIL stream_run: got %0d want 1", State); end
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL stream_latency: got %b want 0", Out_Valid); end
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++; if (Out_Valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", k, Out_Valid); end
      checks++; if (Out_PC !== 32'(4 * k)) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", k, Out_PC, 32'(4 * k)); end
      checks++; if (Out_Instruction !== 32'h1000 + 32'(4 * k)) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", k, Out_Instruction, 32'h1000 + 32'(4 * k)); end
      checks++; if (Out_PCPlus4 !== 32'(4 * k + 4)) begin errors++; $display("FAIL stream_pc4[%0d]: got %h want %h", k, Out_PCPlus4, 32'(4 * k + 4)); end
      checks++; if (Fetch_Count !== 32'(k)) begin errors++; $display("FAIL stream_count[%0d]: got %0d want %0d", k, Fetch_Count, k); end
      tick();
    end
  endtask

  task automatic test_stall();
    Out_Ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (Out_PC !== 32'd16) begin errors++; $display("FAIL stall_head[%0d]: got %h want %h", i, Out_PC, 32'd16); end
      checks++; if (Fetch_Count !== 32'd4) begin errors++; $display("FAIL stall_count[%0d]: got %0d want 4", i, Fetch_Count); end
    end
    checks++; if (IM_Address !== 32'd24) begin errors++; $display("FAIL stall_addr: got %h want %h", IM_Address, 32'd24); end
    Out_Ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (Out_PC !== 32'(16 + 4 * k)) begin errors++; $display("FAIL release_pc[%0d]: got %h want %h", k, Out_PC, 32'(16 + 4 * k)); end
      checks++; if (Fetch_Count !== 32'(4 + k)) begin errors++; $display("FAIL release_count[%0d]: got %0d want %0d", k, Fetch_Count, 4 + k); end
      tick();
    end
  endtask

  task automatic test_redirect();
    Redirect_Valid = 1'b1; Redirect_Target = 32'd128; Out_Ready = 1'b1;
    tick();
    Redirect_Valid = 1'b0;
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b want 0", Out_Valid); end
    checks++; if (IM_Address !== 32'd128) begin errors++; $display("FAIL redir_addr: got %h want %h", IM_Address, 32'd128); end
    checks++; if (Fetch_Count !== 32'd8) begin errors++; $display("FAIL redir_count: got %0d want 8", Fetch_Count); end
    checks++; if (Misaligned !== 1'b0) begin errors++; $display("FAIL redir_aligned: got %b want 0", Misaligned); end
    tick();
    checks++; if (Out_PC !== 32'd128) begin errors++; $display("FAIL redir_pc: got %h want %h", Out_PC, 32'd128); end
    checks++; if (Out_Instruction !== 32'h1080) begin errors++; $display("FAIL redir_instr: got %h want %h", Out_Instruction, 32'h1080); end
    Redirect_Valid = 1'b1; Redirect_Target = 32'h1E;
    tick();
    Redirect_Valid = 1'b0;
    checks++; if (Misaligned !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b want 1", Misaligned); end
    checks++; if (IM_Address !== 32'h1C) begin errors++; $display("FAIL mis_addr: got %h want %h", IM_Address, 32'h1C); end
    checks++; if (Fetch_Count !== 32'd8) begin errors++; $display("FAIL mis_count: got %0d want 8", Fetch_Count); end
    tick();
    checks++; if (Misaligned !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b want 0", Misaligned); end
    checks++; if (Out_PC !== 32'h1C) begin errors++; $display("FAIL mis_pc: got %h want %h", Out_PC, 32'h1C); end
    checks++; if (Out_Instruction !== 32'h101C) begin errors++; $display("FAIL mis_instr: got %h want %h", Out_Instruction, 32'h101C); end
  endtask

  task automatic test_halt();
    Redirect_Valid = 1'b1; Redirect_Target = 32'd8; Out_Ready = 1'b0;
    tick();
    Redirect_Valid = 1'b0;
    tick();
    tick();
    checks++; if (IM_Address !== 32'd16) begin errors++; $display("FAIL halt_pc: got %h want %h", IM_Address, 32'd16); end
    checks++; if (Out_PC !== 32'd8) begin errors++; $display("FAIL halt_head: got %h want %h", Out_PC, 32'd8); end
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    checks++; if (State !== 2'd2) begin errors++; $display("FAIL halt_drain: got %0d want 2", State); end
    checks++; if (IM_Address !== 32'd16) begin errors++; $display("FAIL halt_frozen: got %h want %h", IM_Address, 32'd16); end
    Out_Ready = 1'b1;
    tick();
    checks++; if (Out_PC !== 32'd12) begin errors++; $display("FAIL drain_pc: got %h want %h", Out_PC, 32'd12); end
    checks++; if (State !== 2'd2) begin errors++; $display("FAIL drain_state: got %0d want 2", State); end
    tick();
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", Out_Valid); end
    checks++; if (Fetch_Count !== 32'd10) begin errors++; $display("FAIL drain_count: got %0d want 10", Fetch_Count); end
    tick();
    checks++; if (State !== 2'd3) begin errors++; $display("FAIL halted_state: got %0d want 3", State); end
    Start = 1'b1;
    tick();
    Start = 1'b0;
    checks++; if (State !== 2'd1) begin errors++; $display("FAIL resume_state: got %0d want 1", State); end
    tick();
    checks++; if (Out_PC !== 32'd16) begin errors++; $display("FAIL resume_pc: got %h want %h", Out_PC, 32'd16); end
    checks++; if (Out_Instruction !== 32'h1010) begin errors++; $display("FAIL resume_instr: got %h want %h", Out_Instruction, 32'h1010); end
  endtask

  task automatic test_wrap();
    Redirect_Valid = 1'b1; Redirect_Target = 32'hFFFF_FFF8; Out_Ready = 1'b1;
    tick();
    Redirect_Valid = 1'b0;
    tick();
    checks++; if (Out_PC !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_pc0: got %h want %h", Out_PC, 32'hFFFF_FFF8); end
    tick();
    checks++; if (Out_PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc1: got %h want %h", Out_PC, 32'hFFFF_FFFC); end
    checks++; if (Out_PCPlus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h want %h", Out_PCPlus4, 32'h0); end
    tick();
    checks++; if (Out_PC !== 32'h0) begin errors++; $display("FAIL wrap_pc2: got %h want %h", Out_PC, 32'h0); end
    checks++; if (Out_Instruction !== 32'h1000) begin errors++; $display("FAIL wrap_instr: got %h want %h", Out_Instruction, 32'h1000); end
  endtask

  task automatic test_async_reset();
    Out_Ready = 1'b1;
    tick();
    #2;
    Reset = 1'b1;
    #1;
    checks++; if (IM_Address !== 32'h0) begin errors++; $display("FAIL areset_addr: got %h want %h", IM_Address, 32'h0); end
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", Out_Valid); end
    checks++; if (State !== 2'd0) begin errors++; $display("FAIL areset_state: got %0d want 0", State); end
    checks++; if (Fetch_Count !== 32'h0) begin errors++; $display("FAIL areset_count: got %0d want 0", Fetch_Count); end
    @(negedge Clk);
    Reset = 1'b0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    checks++; if (Out_PC !== 32'h0) begin errors++; $display("FAIL refetch_pc: got %h want %h", Out_PC, 32'h0); end
    checks++; if (Out_Instruction !== 32'h1000) begin errors++; $display("FAIL refetch_instr: got %h want %h", Out_Instruction, 32'h1000); end
  endtask

  // Reference model: one clock of behaviour from the current inputs.
  task automatic model_step();
    int     occ;
    bit     popped;
    bit     pushed;
    entry_t e;
    occ = m_q.size();
    if (Redirect_Valid) begin
      m_q.delete();
      m_pc  = Redirect_Target & ~32'h3;
      m_mis = (Redirect_Target % 4) != 0;
      if (m_state == 2) m_state = 3;
    end else begin
      m_mis  = 1'b0;
      popped = (occ > 0) && Out_Ready;
      pushed = (m_state == 1) && ((occ < 2) || popped);
      if (popped) begin
        m_q.delete(0);
        m_cnt = m_cnt + 1;
      end
      if (pushed) begin
        e.instr = m_pc + 32'h1000;
        e.pc    = m_pc;
        m_q.push_back(e);
        m_pc = m_pc + 4;
      end
      if ((m_state == 0 || m_state == 3) && Start && !Halt) m_state = 1;
      else if (m_state == 1 && Halt) m_state = 2;
      else if (m_state == 2 && occ == 0) m_state = 3;
    end
  endtask

  task automatic test_random();
    Start = 1'b0; Halt = 1'b0; Redirect_Valid = 1'b0; Out_Ready = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    m_q.delete(); m_pc = 32'h0; m_cnt = 32'h0; m_state = 0; m_mis = 1'b0;
    for (int c = 0; c < 600; c++) begin
      Start           = ($urandom_range(0, 7) == 0);
      Halt            = ($urandom_range(0, 15) == 0);
      Redirect_Valid  = ($urandom_range(0, 11) == 0);
      Redirect_Target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                    : 32'($urandom_range(0, 255));
      Out_Ready       = ($urandom_range(0, 2) != 0);
      model_step();
      tick();
      checks++; if (IM_Address !== m_pc) begin errors++; $display("FAIL rnd_addr@%0d: got %h want %h", c, IM_Address, m_pc); end
      checks++; if (State !== 2'(m_state)) begin errors++; $display("FAIL rnd_state@%0d: got %0d want %0d", c, State, m_state); end
      checks++; if (Misaligned !== m_mis) begin errors++; $display("FAIL rnd_mis@%0d: got %b want %b", c, Misaligned, m_mis); end
      checks++; if (Fetch_Count !== m_cnt) begin errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, Fetch_Count, m_cnt); end
      checks++; if (Out_Valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", c, Out_Valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        checks++; if (Out_PC !== m_q[0].pc) begin errors++; $display("FAIL rnd_pc@%0d: got %h want %h", c, Out_PC, m_q[0].pc); end
        checks++; if (Out_Instruction !== m_q[0].instr) begin errors++; $display("FAIL rnd_instr@%0d: got %h want %h", c, Out_Instruction, m_q[0].instr); end
        checks++; if (Out_PCPlus4 !== m_q[0].pc + 32'd4) begin errors++; $display("FAIL rnd_pc4@%0d: got %h want %h", c, Out_PCPlus4, m_q[0].pc + 32'd4); end
      end
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Halt = 1'b0; Redirect_Valid = 1'b0;
    Redirect_Target = 32'h0; Out_Ready = 1'b0;
    @(negedge Clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
